// File: rtl/sentry_ctrl_nwide_if.sv
// rtl/sentry_ctrl_nwide_if.sv - trace, resync and cache-check request bundle for the sentry front end
interface sentry_ctrl_nwide_if #(
    parameter int WIDTH = 4,
    parameter int XLEN  = 64
);
    logic                    trace_ready;
    logic [WIDTH-1:0]        trace_lane_valid;
    logic [WIDTH*32-1:0]     trace_instr;
    logic [WIDTH*XLEN-1:0]   trace_result;
    logic                    trace_en;
    logic                    pc_load;
    logic [XLEN-1:0]         pc_load_value;
    logic                    icache_req_almost_full;
    logic [WIDTH-1:0]        icache_req_valid;
    logic [WIDTH*XLEN-1:0]   icache_req_address;
    logic [WIDTH*XLEN-1:0]   icache_req_inst_result;
    logic                    dcache_req_almost_full;
    logic [WIDTH-1:0]        dcache_req_valid;
    logic [WIDTH-1:0]        dcache_req_store;
    logic [WIDTH*XLEN-1:0]   dcache_req_address;
    logic [31:0]             frame_count;

    // Trace source, resync source and cache request sinks
    modport master (
        output trace_ready, trace_lane_valid, trace_instr, trace_result,
        output pc_load, pc_load_value, icache_req_almost_full, dcache_req_almost_full,
        input  trace_en, icache_req_valid, icache_req_address, icache_req_inst_result,
        input  dcache_req_valid, dcache_req_store, dcache_req_address, frame_count
    );

    // Sentry control front end
    modport slave (
        input  trace_ready, trace_lane_valid, trace_instr, trace_result,
        input  pc_load, pc_load_value, icache_req_almost_full, dcache_req_almost_full,
        output trace_en, icache_req_valid, icache_req_address, icache_req_inst_result,
        output dcache_req_valid, dcache_req_store, dcache_req_address, frame_count
    );
endinterface

// File: rtl/sentry_ctrl_nwide.sv
// rtl/sentry_ctrl_nwide.sv - N-lane trace frame replay with shadow RF and cache check requests
module sentry_ctrl_nwide #(
    parameter int              WIDTH    = 4,
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'('h7528)
) (
    input  logic clk,
    input  logic rst,
    sentry_ctrl_nwide_if.slave bus
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_32     = 7'b0111011;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  rf [32];
    logic [XLEN-1:0]  lane_pc  [WIDTH];
    logic [XLEN-1:0]  wr_data  [WIDTH];
    logic [XLEN-1:0]  eff_addr [WIDTH];
    logic [4:0]       wr_rd    [WIDTH];
    logic [WIDTH-1:0] wr_en;
    logic [WIDTH-1:0] is_load;
    logic [WIDTH-1:0] is_store;
    logic [XLEN-1:0]  next_pc;
    logic             pop;
    logic             unused_funct3;

    assign pop = bus.trace_ready & ~bus.icache_req_almost_full
               & ~bus.dcache_req_almost_full & ~bus.pc_load;
    assign bus.trace_en = pop;

    // Walk the lanes in order: rebuild lane PCs, decode, forward rs1 from earlier writers, form addresses
    always_comb begin
        logic [XLEN-1:0] run_pc;
        logic [XLEN-1:0] opnd;
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] imm;
        logic [31:0]     ins;
        logic [6:0]      opc;
        logic [4:0]      rs1;
        logic            link;
        logic            jmp;
        logic            writer;
        run_pc        = pc_q;
        next_pc       = pc_q;
        wr_en         = '0;
        is_load       = '0;
        is_store      = '0;
        unused_funct3 = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            ins    = bus.trace_instr[32*i +: 32];
            res    = bus.trace_result[XLEN*i +: XLEN];
            opc    = ins[6:0];
            rs1    = ins[19:15];
            unused_funct3 = unused_funct3 ^ (^ins[14:12]);
            link   = (opc == OP_JAL) || (opc == OP_JALR);
            jmp    = link || (opc == OP_BRANCH);
            writer = link || (opc == OP_LUI) || (opc == OP_AUIPC) || (opc == OP_LOAD)
                   || (opc == OP_OP) || (opc == OP_IMM) || (opc == OP_32) || (opc == OP_IMM_32);
            lane_pc[i]  = run_pc;
            is_load[i]  = bus.trace_lane_valid[i] && (opc == OP_LOAD);
            is_store[i] = bus.trace_lane_valid[i] && (opc == OP_STORE);
            wr_rd[i]    = ins[11:7];
            wr_en[i]    = bus.trace_lane_valid[i] && writer && (ins[11:7] != 5'd0);
            wr_data[i]  = link ? run_pc + XLEN'(4) : res;
            // Only writers from lower lanes forward; the latest such lane overrides earlier ones
            opnd = rf[rs1];
            for (int k = 0; k < i; k++) begin
                if (wr_en[k] && (wr_rd[k] == rs1)) begin
                    opnd = wr_data[k];
                end
            end
            if (rs1 == 5'd0) begin
                opnd = '0;
            end
            if (opc == OP_STORE) begin
                imm = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
            end else begin
                imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
            end
            eff_addr[i] = opnd + imm;
            run_pc = jmp ? res : run_pc + XLEN'(4);
            // Valid lanes are contiguous, so the last valid lane's successor is pc[L]
            if (bus.trace_lane_valid[i]) begin
                next_pc = run_pc;
            end
        end
    end

    // Architectural state: frame PC and shadow register file, committed only on a pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
            for (int r = 0; r < 32; r++) begin
                rf[r] <= '0;
            end
        end else if (bus.pc_load) begin
            pc_q <= bus.pc_load_value;
        end else if (pop) begin
            pc_q <= next_pc;
            for (int i = 0; i < WIDTH; i++) begin
                if (wr_en[i]) begin
                    rf[wr_rd[i]] <= wr_data[i];
                end
            end
        end
    end

    // Registered cache check requests, live for exactly the cycle after a pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.icache_req_valid       <= '0;
            bus.icache_req_address     <= '0;
            bus.icache_req_inst_result <= '0;
            bus.dcache_req_valid       <= '0;
            bus.dcache_req_store       <= '0;
            bus.dcache_req_address     <= '0;
            bus.frame_count            <= '0;
        end else if (pop) begin
            bus.icache_req_valid       <= bus.trace_lane_valid;
            bus.icache_req_inst_result <= bus.trace_result;
            bus.dcache_req_valid       <= is_load | is_store;
            bus.dcache_req_store       <= is_store;
            bus.frame_count            <= bus.frame_count + 32'd1;
            for (int i = 0; i < WIDTH; i++) begin
                bus.icache_req_address[XLEN*i +: XLEN] <= lane_pc[i];
                bus.dcache_req_address[XLEN*i +: XLEN] <= eff_addr[i];
            end
        end else begin
            bus.icache_req_valid <= '0;
            bus.dcache_req_valid <= '0;
            bus.dcache_req_store <= '0;
        end
    end
endmodule
